// File: rtl/stream_arb_2to1.sv
// stream_arb_2to1: two-source packet arbiter with a single registered output
// stage. A source keeps the grant until its last beat is accepted; sources
// alternate at packet granularity so neither can starve the other.
module stream_arb_2to1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              sel,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              sel_q, sel_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;

  logic              out_free;
  logic              xfer0, xfer1;

  // Next-state logic: grant selection, beat transfer and output-register pop.
  // Readiness depends only on state and the output register, never on valid.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    sel_d     = sel_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;

    out_free  = ~m_valid_q | m_ready;
    s0_ready  = (state_q == LOCK0) & out_free;
    s1_ready  = (state_q == LOCK1) & out_free;
    xfer0     = s0_valid & s0_ready;
    xfer1     = s1_valid & s1_ready;

    // Downstream pop; a push below in the same cycle overrides it.
    if (m_valid_q & m_ready) begin
      m_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Source 0 wins if it is alone or if it holds the round-robin priority.
        if (s0_valid & (~s1_valid | ~prio_q)) begin
          state_d = LOCK0;
          sel_d   = 1'b0;
        end else if (s1_valid) begin
          state_d = LOCK1;
          sel_d   = 1'b1;
        end
      end
      LOCK0: begin
        if (xfer0) begin
          m_valid_d = 1'b1;
          m_data_d  = s0_data;
          m_last_d  = s0_last;
          if (s0_last) begin
            state_d = IDLE;
            prio_d  = 1'b1;
          end
        end
      end
      LOCK1: begin
        if (xfer1) begin
          m_valid_d = 1'b1;
          m_data_d  = s1_data;
          m_last_d  = s1_last;
          if (s1_last) begin
            state_d = IDLE;
            prio_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      sel_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign sel     = sel_q;
  assign busy    = (state_q != IDLE);

endmodule
